feature_quantizer_packer: RTL and testbench

Streaming front end that sits directly upstream of the first sparse LogicNets layer. It accepts raw unsigned feature words one per beat over a valid/ready stream. Each word is quantized to a 2-bit code against per-feature thresholds, and the codes are packed into one flat input vector per sample. Complete vectors are presented on a registered valid/ready output that drives the layer-0 neuron inputs, with one-deep buffering and frame-error detection.

---
 rtl/feature_quantizer_packer_if.sv | 24 ++
 rtl/feature_quantizer_packer.sv | 128 ++++++++++++
 tb/tb_feature_quantizer_packer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/feature_quantizer_packer_if.sv
// Stream bundle for the quantizer/packer: raw feature beats in, packed code vectors out.
// The slave modport is the block's view; master is the upstream/downstream environment.
interface feature_quantizer_packer_if #(
  parameter int NUM_FEATURES = 2,
  parameter int IN_WIDTH     = 8
);
  logic [IN_WIDTH-1:0]       s_data;
  logic                      s_valid;
  logic                      s_last;
  logic                      s_ready;
  logic [2*NUM_FEATURES-1:0] m_data;
  logic                      m_valid;
  logic                      m_ready;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid
  );
endinterface

// File: rtl/feature_quantizer_packer.sv
// Quantizes raw feature words to 2-bit codes, packs one sample per output vector,
// with a one-deep pending buffer behind the output register and framing-error counting.
module feature_quantizer_packer #(
  parameter int NUM_FEATURES = 2,
  parameter int IN_WIDTH     = 8,
  parameter logic [3*NUM_FEATURES*IN_WIDTH-1:0] THRESHOLDS =
    {8'd192, 8'd128, 8'd64, 8'd192, 8'd128, 8'd64}
) (
  input  logic                          clk,
  input  logic                          rst,
  feature_quantizer_packer_if.slave     bus,
  output logic                          frame_err,
  output logic [7:0]                    err_count
);
  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int VEC_W = 2 * NUM_FEATURES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  typedef enum logic {COLLECT, PENDING} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   collect_q, collect_d;
  logic [VEC_W-1:0]   pend_q, pend_d;
  logic [VEC_W-1:0]   m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               frame_err_q, frame_err_d;
  logic [7:0]         err_count_q, err_count_d;

  logic [1:0]         code;
  logic [VEC_W-1:0]   vec_new;
  logic               accept;
  logic               drain;
  logic               out_free;

  // Code is the number of this feature's thresholds that the word meets or exceeds.
  always_comb begin
    code = 2'd0;
    for (int j = 0; j < 3; j++) begin
      if (bus.s_data >= THRESHOLDS[(3*int'(idx_q)+j)*IN_WIDTH +: IN_WIDTH])
        code = code + 2'd1;
    end
    vec_new = collect_q;
    vec_new[2*int'(idx_q) +: 2] = code;
  end

  assign bus.s_ready = rst && (state_q == COLLECT);
  assign accept      = bus.s_valid && bus.s_ready;
  assign drain       = m_valid_q && bus.m_ready;
  assign out_free    = !m_valid_q || bus.m_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    collect_d   = collect_q;
    pend_d      = pend_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    err_count_d = err_count_q;

    if (drain)
      m_valid_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if ((idx_q == LAST_IDX) && bus.s_last) begin
            idx_d     = '0;
            collect_d = '0;
            if (out_free) begin
              m_data_d  = vec_new;
              m_valid_d = 1'b1;
            end else begin
              pend_d  = vec_new;
              state_d = PENDING;
            end
          end else if ((idx_q == LAST_IDX) || bus.s_last) begin
            // Sample too short or too long: drop everything collected so far.
            idx_d       = '0;
            collect_d   = '0;
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF)
              err_count_d = err_count_q + 8'd1;
          end else begin
            collect_d = vec_new;
            idx_d     = idx_q + IDX_W'(1);
          end
        end
      end
      PENDING: begin
        if (drain) begin
          m_data_d  = pend_q;
          m_valid_d = 1'b1;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      collect_q   <= '0;
      pend_q      <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      collect_q   <= collect_d;
      pend_q      <= pend_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign frame_err   = frame_err_q;
  assign err_count   = err_count_q;
endmodule

// File: tb/tb_feature_quantizer_packer.sv
// Directed bench for feature_quantizer_packer: vector table for quantization plus
// hand-written backpressure, framing-error, saturation and mid-sample reset sequences.
module tb_feature_quantizer_packer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_err;
  logic [7:0] err_count;
  int         checks = 0;
  int         errors = 0;

  feature_quantizer_packer_if #(.NUM_FEATURES(2), .IN_WIDTH(8)) bus ();

  feature_quantizer_packer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] f0;
    logic [7:0] f1;
    logic [3:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one beat at the falling edge, let the rising edge take it, settle 1 time unit.
  task automatic driveBeat(input logic [7:0] data, input logic last);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_last  = last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] f0, input logic [7:0] f1);
    driveBeat(f0, 1'b0);
    driveBeat(f1, 1'b1);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;

    vecs[0] = '{8'd100, 8'd200, 4'b1101};
    vecs[1] = '{8'd63,  8'd0,   4'b0000};
    vecs[2] = '{8'd64,  8'd0,   4'b0001};
    vecs[3] = '{8'd191, 8'd0,   4'b0010};
    vecs[4] = '{8'd192, 8'd0,   4'b0011};
    vecs[5] = '{8'd255, 8'd0,   4'b0011};
    vecs[6] = '{8'd0,   8'd128, 4'b1000};
    vecs[7] = '{8'd127, 8'd64,  4'b0101};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_s_ready", bus.s_ready, 0);
    checkOutput("reset_m_valid", bus.m_valid, 0);
    checkOutput("reset_m_data", bus.m_data, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post_reset_s_ready", bus.s_ready, 1);

    // Back-to-back table samples with m_ready=1
    for (int i = 0; i < 8; i++) begin
      driveBeat(vecs[i].f0, 1'b0);
      checkOutput($sformatf("vec%0d_mid_valid", i), bus.m_valid, 0);
      driveBeat(vecs[i].f1, 1'b1);
      checkOutput($sformatf("vec%0d_valid", i), bus.m_valid, 1);
      checkOutput($sformatf("vec%0d_data", i), bus.m_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_frame_err", i), frame_err, 0);
    end
    idle(1);
    checkOutput("drain_valid", bus.m_valid, 0);

    // Backpressure: first sample held, second pending
    @(negedge clk);
    bus.m_ready = 1'b0;
    applyStimulus(8'd100, 8'd200);
    checkOutput("bp_first_valid", bus.m_valid, 1);
    checkOutput("bp_first_data", bus.m_data, 4'b1101);
    checkOutput("bp_ready_before", bus.s_ready, 1);
    applyStimulus(8'd192, 8'd0);
    checkOutput("bp_pending_s_ready", bus.s_ready, 0);
    checkOutput("bp_hold_data", bus.m_data, 4'b1101);
    idle(2);
    checkOutput("bp_hold_data2", bus.m_data, 4'b1101);
    checkOutput("bp_hold_valid", bus.m_valid, 1);
    checkOutput("bp_still_pending", bus.s_ready, 0);
    @(negedge clk);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_second_valid", bus.m_valid, 1);
    checkOutput("bp_second_data", bus.m_data, 4'b0011);
    checkOutput("bp_ready_back", bus.s_ready, 1);
    idle(1);
    checkOutput("bp_drained", bus.m_valid, 0);

    // Framing errors
    driveBeat(8'd50, 1'b1);
    checkOutput("fe1_pulse", frame_err, 1);
    checkOutput("fe1_count", err_count, 1);
    checkOutput("fe1_no_valid", bus.m_valid, 0);
    idle(1);
    checkOutput("fe1_pulse_end", frame_err, 0);
    driveBeat(8'd10, 1'b0);
    checkOutput("fe2_no_early_pulse", frame_err, 0);
    driveBeat(8'd20, 1'b0);
    checkOutput("fe2_pulse", frame_err, 1);
    checkOutput("fe2_count", err_count, 2);
    checkOutput("fe2_no_valid", bus.m_valid, 0);
    applyStimulus(8'd64, 8'd128);
    checkOutput("fe_recover_valid", bus.m_valid, 1);
    checkOutput("fe_recover_data", bus.m_data, 4'b1001);
    checkOutput("fe_recover_frame_err", frame_err, 0);
    idle(1);

    // Saturation: 2 + 300 errors clamps at 255
    for (int i = 0; i < 300; i++) begin
      driveBeat(8'd0, 1'b1);
      if (i == 252) checkOutput("sat_reach_255", err_count, 255);
    end
    checkOutput("sat_count", err_count, 255);
    checkOutput("sat_pulse", frame_err, 1);
    idle(1);
    checkOutput("sat_hold", err_count, 255);

    // Mid-sample reset
    driveBeat(8'd255, 1'b0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("mr_s_ready_low", bus.s_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("mr_m_valid", bus.m_valid, 0);
    checkOutput("mr_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(8'd255, 8'd0);
    checkOutput("mr_sample_valid", bus.m_valid, 1);
    checkOutput("mr_sample_data", bus.m_data, 4'b0011);
    checkOutput("mr_no_frame_err", frame_err, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
